// File: rtl/puf_vote_sequencer.sv
// Runs three PUF evaluations per challenge and resolves them with a bitwise 2-of-3 vote.
// Optional macro PUF_VOTE_EARLY_EXIT_EN: skip the third evaluation when the first two samples agree.
module puf_vote_sequencer #(
  parameter int unsigned CHAL_W      = 64,
  parameter int unsigned RESP_W      = 32,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CHAL_W-1:0] challenge,
  output logic              busy,
  output logic [CHAL_W-1:0] puf_chal,
  output logic              puf_trig,
  input  logic              puf_done,
  input  logic [RESP_W-1:0] puf_resp,
  output logic [RESP_W-1:0] resp_out,
  output logic [RESP_W-1:0] unstable_mask,
  output logic              resp_valid,
  output logic              timeout_err
);

  typedef enum logic [2:0] {IDLE, SETTLE, TRIG, WAIT, VOTE, DONE} state_t;

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam state_t EVAL_ENTRY = (SETTLE_CYC == 0) ? TRIG : SETTLE;

  state_t              state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [RESP_W-1:0]   s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [CHAL_W-1:0]   chal_q, chal_d;
  logic                trig_q, trig_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                terr_q, terr_d;
  logic [RESP_W-1:0]   resp_q, resp_d;
  logic [RESP_W-1:0]   mask_q, mask_d;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    set_cnt_d = set_cnt_q;
    to_cnt_d  = to_cnt_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    chal_d    = chal_q;
    terr_d    = terr_q;
    resp_d    = resp_q;
    mask_d    = mask_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          chal_d    = challenge;
          k_d       = '0;
          terr_d    = 1'b0;
          set_cnt_d = '0;
          state_d   = EVAL_ENTRY;
        end
      end
      SETTLE: begin
        if (set_cnt_q == SET_LAST) state_d = TRIG;
        else                       set_cnt_d = set_cnt_q + 1'b1;
      end
      TRIG: begin
        to_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (puf_done) begin
          case (k_q)
            2'd0:    s0_d = puf_resp;
            2'd1:    s1_d = puf_resp;
            default: s2_d = puf_resp;
          endcase
          if (k_q == 2'd2) begin
            state_d = VOTE;
          end else begin
            k_d       = k_q + 2'd1;
            set_cnt_d = '0;
            state_d   = EVAL_ENTRY;
          end
`ifdef PUF_VOTE_EARLY_EXIT_EN
          // Mirroring the agreed sample into slot 2 makes the normal vote yield s0 with an all-zero mask.
          if (k_q == 2'd1 && puf_resp == s0_q) begin
            s2_d    = puf_resp;
            state_d = VOTE;
          end
`endif
        end else if (to_cnt_q == TO_LAST) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      VOTE: begin
        resp_d  = (s0_q & s1_q) | (s1_q & s2_q) | (s2_q & s0_q);
        mask_d  = (s0_q ^ s1_q) | (s1_q ^ s2_q);
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    busy_d  = (state_d != IDLE);
    trig_d  = (state_d == TRIG);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      set_cnt_q <= '0;
      to_cnt_q  <= '0;
      s0_q      <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      chal_q    <= '0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      terr_q    <= 1'b0;
      resp_q    <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      set_cnt_q <= set_cnt_d;
      to_cnt_q  <= to_cnt_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      chal_q    <= chal_d;
      trig_q    <= trig_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      terr_q    <= terr_d;
      resp_q    <= resp_d;
      mask_q    <= mask_d;
    end
  end

  assign busy          = busy_q;
  assign puf_chal      = chal_q;
  assign puf_trig      = trig_q;
  assign resp_out      = resp_q;
  assign unstable_mask = mask_q;
  assign resp_valid    = valid_q;
  assign timeout_err   = terr_q;

endmodule
